spi_apb_master: RTL and testbench

SPI-slave (mode 0) to APB-master bridge that sequences the GPIO expander register block. Decodes 16-bit SPI frames from an external host into single APB read or write transfers on the expander's APB port, and returns read data on MISO. Sits between the chip-level SPI pins and the GPIO register block.

---
 rtl/spi_apb_master_if.sv | 22 ++
 rtl/spi_apb_master.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_apb_master.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_apb_master_if.sv
// APB bus between the SPI bridge (master) and the GPIO expander register block (slave).
interface spi_apb_master_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [7:0]            pwdata;
  logic [7:0]            prdata;
  logic                  pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/spi_apb_master.sv
// SPI mode-0 slave to APB master bridge: each 16-bit frame becomes one APB read or write.
// Define SPI_APB_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES without pready.
module spi_apb_master #(
  parameter int         ADDR_WIDTH     = 3,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] ERR_BYTE       = 8'hFF
) (
  input  logic pclk,
  input  logic presetn,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic err,
  output logic frame_done,
  spi_apb_master_if.master apb
);

  // state     | meaning
  // IDLE      | waiting for cs_n fall
  // CMD       | shifting command byte
  // RD_SETUP  | APB read, setup phase
  // RD_ACCESS | APB read, waiting for pready
  // DATA      | shifting second byte
  // WR_SETUP  | APB write, setup phase
  // WR_ACCESS | APB write, waiting for pready
  // WAIT_CS   | frame complete, waiting for cs_n rise
  typedef enum logic [2:0] {
    IDLE, CMD, RD_SETUP, RD_ACCESS, DATA, WR_SETUP, WR_ACCESS, WAIT_CS
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_apb_master: TIMEOUT_CYCLES must be at least 1");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 7) begin : g_bad_addr
    $error("spi_apb_master: ADDR_WIDTH must be 1..7");
  end

  state_t      state;
  logic [1:0]  sclk_q, cs_q, mosi_q;
  logic        sclk_d, cs_d;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic [4:0]  bit_cnt;
  logic [7:0]  rx_shift, tx_shift;
  logic        rd_frame, abort;
  logic        in_frame, tmo_hit, acc_end;
  logic [7:0]  rd_data;

  // cs_n synchroniser resets high so leaving reset never looks like a frame start
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sclk_q <= 2'b00;
      cs_q   <= 2'b11;
      mosi_q <= 2'b00;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[0], sclk};
      cs_q   <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      sclk_d <= sclk_q[1];
      cs_d   <= cs_q[1];
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[1] & sclk_d;
  assign cs_fall   = ~cs_q[1] & cs_d;
  assign cs_rise   = cs_q[1] & ~cs_d;
  assign mosi_s    = mosi_q[1];

  assign in_frame = (state == CMD) || (state == RD_SETUP) ||
                    (state == RD_ACCESS) || (state == DATA);

`ifdef SPI_APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt <= '0;
    end else if (state == RD_SETUP || state == WR_SETUP) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if ((state == RD_ACCESS || state == WR_ACCESS) && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == '0) && !apb.pready;
`else
  assign tmo_hit = 1'b0;
`endif

  assign acc_end = apb.pready || tmo_hit;
  assign rd_data = tmo_hit ? ERR_BYTE : apb.prdata;
  assign miso    = rd_frame & tx_shift[7];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rd_frame    <= 1'b0;
      abort       <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
    end else begin
      frame_done <= 1'b0;

      if (sclk_rise && in_frame && bit_cnt != 5'd16) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 5'd1;
        // host is about to sample byte1 bit 7 before read data arrived
        if (bit_cnt == 5'd8 && (state == RD_SETUP || state == RD_ACCESS))
          err <= 1'b1;
      end

      if (sclk_fall && rd_frame && bit_cnt >= 5'd9 && bit_cnt <= 5'd15)
        tx_shift <= {tx_shift[6:0], 1'b0};

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rd_frame <= 1'b0;
            abort    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CMD: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_cnt == 5'd8) begin
            apb.paddr <= rx_shift[ADDR_WIDTH-1:0];
            if (rx_shift[7]) begin
              state <= DATA;
            end else begin
              state      <= RD_SETUP;
              rd_frame   <= 1'b1;
              apb.psel   <= 1'b1;
              apb.pwrite <= 1'b0;
            end
          end
        end
        RD_SETUP: begin
          if (cs_rise) abort <= 1'b1;
          apb.penable <= 1'b1;
          state       <= RD_ACCESS;
        end
        RD_ACCESS: begin
          if (cs_rise) abort <= 1'b1;
          if (acc_end) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            tx_shift    <= rd_data;
            if (tmo_hit) err <= 1'b1;
            if (abort || cs_rise) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rd_frame <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (cs_rise) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rd_frame <= 1'b0;
          end else if (bit_cnt == 5'd16) begin
            if (rd_frame) begin
              state      <= WAIT_CS;
              rd_frame   <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state      <= WR_SETUP;
              apb.psel   <= 1'b1;
              apb.pwrite <= 1'b1;
              apb.pwdata <= rx_shift;
            end
          end
        end
        WR_SETUP: begin
          if (cs_rise) abort <= 1'b1;
          apb.penable <= 1'b1;
          state       <= WR_ACCESS;
        end
        WR_ACCESS: begin
          if (cs_rise) abort <= 1'b1;
          if (acc_end) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            if (tmo_hit) err <= 1'b1;
            if (abort || cs_rise) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= WAIT_CS;
              frame_done <= 1'b1;
            end
          end
        end
        WAIT_CS: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_apb_master.sv
// Self-checking bench for spi_apb_master: SPI host driver, APB register-block model, reference memory.
module tb_spi_apb_master;
  localparam int AW = 3;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, busy, err, frame_done;

  spi_apb_master_if #(.ADDR_WIDTH(AW)) apb ();

  spi_apb_master #(
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .ERR_BYTE(8'hFF)
  ) dut (
    .pclk(pclk), .presetn(presetn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .busy(busy), .err(err), .frame_done(frame_done), .apb(apb)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int half = 5;

  // APB register block model
  int   wait_states = 0;
  logic hold_low = 1'b0;
  int   acc_cnt = 0;
  logic [7:0] slave_mem [0:7] = '{default: 8'h00};
  logic [7:0] ref_mem   [0:7] = '{default: 8'h00};

  always @(posedge pclk)
    acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;
  assign apb.pready = hold_low ? 1'b0 : (acc_cnt >= wait_states);
  assign apb.prdata = slave_mem[apb.paddr];

  // bus monitor
  int fd_cnt = 0, xfer_cnt = 0, psel_cyc = 0, pen_cyc = 0, proto_err = 0;
  logic in_x = 1'b0;
  logic [AW-1:0] a0, last_addr;
  logic [7:0] w0, last_wdata;
  logic r0, last_write;

  always @(negedge pclk) begin
    if (apb.psel) begin
      if (!in_x) begin
        in_x = 1'b1;
        a0 = apb.paddr; w0 = apb.pwdata; r0 = apb.pwrite;
        if (apb.penable) proto_err++;
      end else begin
        if (apb.paddr !== a0 || apb.pwdata !== w0 || apb.pwrite !== r0) proto_err++;
        if (!apb.penable) proto_err++;
      end
      psel_cyc++;
      if (apb.penable) pen_cyc++;
      if (apb.penable && apb.pready) begin
        xfer_cnt++;
        last_addr = apb.paddr; last_wdata = apb.pwdata; last_write = apb.pwrite;
        if (apb.pwrite) slave_mem[apb.paddr] = apb.pwdata;
      end
    end else begin
      in_x = 1'b0;
    end
    if (frame_done) fd_cnt++;
  end

  int fd0, x0, ps0, pe0, pr0;
  logic [15:0] rx;

  task automatic snap();
    fd0 = fd_cnt; x0 = xfer_cnt; ps0 = psel_cyc; pe0 = pen_cyc; pr0 = proto_err;
  endtask

  task automatic spi_bits(input logic [15:0] tx, input int nbits, output logic [15:0] rxo);
    rxo = '0;
    @(negedge pclk) cs_n = 1'b0;
    repeat (half) @(negedge pclk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[15-i];
      repeat (half) @(negedge pclk);
      sclk = 1'b1;
      rxo[15-i] = miso;
      repeat (half) @(negedge pclk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    for (int k = 0; k < 200 && fd_cnt == fd0; k++) @(negedge pclk);
    repeat (half) @(negedge pclk);
    cs_n = 1'b1;
    repeat (8) @(negedge pclk);
  endtask

  // full frame; don't-care command bits are randomised
  task automatic frame(input logic rw, input logic [2:0] addr, input logic [7:0] data);
    logic [15:0] tx;
    logic [3:0] junk;
    junk = 4'($urandom);
    tx = {rw, junk, addr, data};
    snap();
    spi_bits(tx, 16, rx);
    spi_end();
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    total++;
    if ({apb.psel, apb.penable, apb.pwrite, miso, busy, err, frame_done} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {apb.psel, apb.penable, apb.pwrite, miso, busy, err, frame_done});
    end
    total++;
    if (apb.paddr !== 3'd0 || apb.pwdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_bus paddr=%0d pwdata=%h exp 0/00", apb.paddr, apb.pwdata);
    end
    @(negedge pclk) presetn = 1'b1;
    repeat (5) @(negedge pclk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_write();
    wait_states = 0;
    ref_mem[0] = 8'hA5;
    frame(1'b1, 3'd0, 8'hA5);
    total++;
    if (xfer_cnt - x0 !== 1 || last_addr !== 3'd0 || last_wdata !== 8'hA5 || last_write !== 1'b1) begin
      bad++;
      $display("FAIL write_xfer n=%0d addr=%0d data=%h wr=%b exp 1/0/a5/1",
               xfer_cnt - x0, last_addr, last_wdata, last_write);
    end
    total++;
    if (psel_cyc - ps0 !== 2 || pen_cyc - pe0 !== 1) begin
      bad++;
      $display("FAIL write_len psel=%0d penable=%0d exp 2/1", psel_cyc - ps0, pen_cyc - pe0);
    end
    total++;
    if (fd_cnt - fd0 !== 1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL write_status fd=%0d err=%b busy=%b exp 1/0/0", fd_cnt - fd0, err, busy);
    end
    total++;
    if (slave_mem[0] !== ref_mem[0] || proto_err - pr0 !== 0) begin
      bad++;
      $display("FAIL write_mem got=%h exp=%h proto=%0d", slave_mem[0], ref_mem[0], proto_err - pr0);
    end
  endtask

  task automatic test_read();
    ref_mem[3] = 8'h5A;
    frame(1'b1, 3'd3, 8'h5A);
    frame(1'b0, 3'd3, 8'h00);
    total++;
    if (rx[7:0] !== ref_mem[3]) begin
      bad++; $display("FAIL read_miso got=%h exp=%h", rx[7:0], ref_mem[3]);
    end
    total++;
    if (last_addr !== 3'd3 || last_write !== 1'b0 || xfer_cnt - x0 !== 1) begin
      bad++;
      $display("FAIL read_xfer addr=%0d wr=%b n=%0d exp 3/0/1", last_addr, last_write, xfer_cnt - x0);
    end
    total++;
    if (err !== 1'b0 || fd_cnt - fd0 !== 1 || psel_cyc - ps0 !== 2) begin
      bad++;
      $display("FAIL read_status err=%b fd=%0d psel=%0d exp 0/1/2", err, fd_cnt - fd0, psel_cyc - ps0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] r;
    snap();
    spi_bits({1'b1, 4'h0, 3'd5, 8'h77}, 12, r);
    repeat (6) @(negedge pclk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_mid got=%b exp=1", busy); end
    cs_n = 1'b1;
    repeat (40) @(negedge pclk);
    total++;
    if (busy !== 1'b0 || psel_cyc - ps0 !== 0 || fd_cnt - fd0 !== 0) begin
      bad++;
      $display("FAIL abort_discard busy=%b psel=%0d fd=%0d exp 0/0/0", busy, psel_cyc - ps0, fd_cnt - fd0);
    end
    ref_mem[1] = 8'h3C;
    frame(1'b1, 3'd1, 8'h3C);
    total++;
    if (slave_mem[1] !== 8'h3C || slave_mem[5] !== ref_mem[5] || last_addr !== 3'd1) begin
      bad++;
      $display("FAIL abort_next mem1=%h mem5=%h addr=%0d exp 3c/%h/1", slave_mem[1], slave_mem[5],
               last_addr, ref_mem[5]);
    end
  endtask

  task automatic test_wait_states();
    wait_states = 2;
    ref_mem[2] = 8'h11;
    frame(1'b1, 3'd2, 8'h11);
    wait_states = 0;
    total++;
    if (pen_cyc - pe0 !== 3 || psel_cyc - ps0 !== 4) begin
      bad++;
      $display("FAIL wait_len penable=%0d psel=%0d exp 3/4", pen_cyc - pe0, psel_cyc - ps0);
    end
    total++;
    if (proto_err - pr0 !== 0 || slave_mem[2] !== 8'h11 || fd_cnt - fd0 !== 1) begin
      bad++;
      $display("FAIL wait_data proto=%0d mem=%h fd=%0d exp 0/11/1", proto_err - pr0, slave_mem[2], fd_cnt - fd0);
    end
  endtask

  task automatic test_late_read();
    wait_states = 12;
    frame(1'b0, 3'd2, 8'h00);
    wait_states = 0;
    total++;
    if (err !== 1'b1 || xfer_cnt - x0 !== 1 || fd_cnt - fd0 !== 1) begin
      bad++;
      $display("FAIL late_read err=%b n=%0d fd=%0d exp 1/1/1", err, xfer_cnt - x0, fd_cnt - fd0);
    end
    frame(1'b0, 3'd2, 8'h00);
    total++;
    if (err !== 1'b0 || rx[7:0] !== ref_mem[2]) begin
      bad++;
      $display("FAIL late_recover err=%b data=%h exp 0/%h", err, rx[7:0], ref_mem[2]);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] r;
    hold_low = 1'b1;
    spi_bits({1'b0, 4'h0, 3'd3, 8'h00}, 8, r);
    repeat (4) @(negedge pclk);
    total++;
    if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin
      bad++; $display("FAIL rst_in_access psel=%b penable=%b exp 1/1", apb.psel, apb.penable);
    end
    #2 presetn = 1'b0;
    #1;
    total++;
    if ({apb.psel, apb.penable, miso, busy} !== 4'b0) begin
      bad++;
      $display("FAIL rst_async got=%b exp=0000", {apb.psel, apb.penable, miso, busy});
    end
    @(negedge pclk);
    cs_n = 1'b1; sclk = 1'b0; hold_low = 1'b0;
    @(negedge pclk) presetn = 1'b1;
    repeat (6) @(negedge pclk);
    frame(1'b0, 3'd3, 8'h00);
    total++;
    if (rx[7:0] !== ref_mem[3] || err !== 1'b0 || fd_cnt - fd0 !== 1) begin
      bad++;
      $display("FAIL rst_recover data=%h err=%b fd=%0d exp %h/0/1", rx[7:0], err, fd_cnt - fd0, ref_mem[3]);
    end
  endtask

`ifdef SPI_APB_TIMEOUT_EN
  task automatic test_timeout();
    hold_low = 1'b1;
    half = 20;
    frame(1'b0, 3'd4, 8'h00);
    hold_low = 1'b0;
    half = 5;
    total++;
    if (pen_cyc - pe0 !== 16 || psel_cyc - ps0 !== 17 || xfer_cnt - x0 !== 0) begin
      bad++;
      $display("FAIL tmo_len penable=%0d psel=%0d n=%0d exp 16/17/0", pen_cyc - pe0, psel_cyc - ps0, xfer_cnt - x0);
    end
    total++;
    if (err !== 1'b1 || rx[7:0] !== 8'hFF || fd_cnt - fd0 !== 1) begin
      bad++;
      $display("FAIL tmo_status err=%b data=%h fd=%0d exp 1/ff/1", err, rx[7:0], fd_cnt - fd0);
    end
    @(negedge pclk) cs_n = 1'b0;
    repeat (8) @(negedge pclk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear err=%b exp=0", err); end
    cs_n = 1'b1;
    repeat (10) @(negedge pclk);
  endtask
`endif

  task automatic test_random();
    logic rw;
    logic [2:0] a;
    logic [7:0] d;
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom);
      a = 3'($urandom);
      d = 8'($urandom);
      wait_states = int'($urandom_range(0, 2));
      if (rw) ref_mem[a] = d;
      frame(rw, a, d);
      total++;
      if (fd_cnt - fd0 !== 1 || xfer_cnt - x0 !== 1 || proto_err - pr0 !== 0 || err !== 1'b0 ||
          pen_cyc - pe0 !== wait_states + 1) begin
        bad++;
        $display("FAIL rand_xfer[%0d] fd=%0d n=%0d proto=%0d err=%b pen=%0d exp 1/1/0/0/%0d",
                 n, fd_cnt - fd0, xfer_cnt - x0, proto_err - pr0, err, pen_cyc - pe0, wait_states + 1);
      end
      total++;
      if (rw ? (slave_mem[a] !== ref_mem[a]) : (rx[7:0] !== ref_mem[a])) begin
        bad++;
        $display("FAIL rand_data[%0d] rw=%b addr=%0d got=%h exp=%h", n, rw, a,
                 rw ? slave_mem[a] : rx[7:0], ref_mem[a]);
      end
    end
    wait_states = 0;
  endtask

  task automatic test_final_mem();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (slave_mem[i] !== ref_mem[i]) begin
        bad++; $display("FAIL final_mem[%0d] got=%h exp=%h", i, slave_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_wait_states();
    test_late_read();
    test_reset_mid_access();
`ifdef SPI_APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_final_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
